// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer (AND, OR, ADD, SUB and optional SLT).
// The operands are processed LSB-first at one bit per clock. The carry is
// carried from each bit to the next in a single register.
// Optional feature macro: ALU_SERIAL_SLT_EN. When it is defined, funct 42 (SLT)
// is supported and the FIX state exists. When it is not defined, funct 42 is
// rejected with err.
// Handshake: start is sampled only in IDLE. done is a one-cycle pulse, and
// result, zero and err are valid and stable during it. busy is high from the
// acceptance edge up to the edge at which done falls. A start outside IDLE is
// dropped; it is never queued.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;

`ifdef ALU_SERIAL_SLT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sh;
    logic [5:0]       op;
    logic             c;
`ifdef ALU_SERIAL_SLT_EN
    logic             c_msb_in;
    logic             c_out;
    logic             s_msb;
    logic             less;
`endif

    logic             legal_f;
    logic             inv_new;
    logic             inv;
    logic             bx;
    logic             sum;
    logic             c_nxt;
    logic             bit_out;
    logic [WIDTH-1:0] shifted;

    // Decode the incoming request and compute the bit slice for the current bit.
    always_comb begin
        legal_f = (funct == F_ADD) || (funct == F_SUB) ||
                  (funct == F_AND) || (funct == F_OR);
`ifdef ALU_SERIAL_SLT_EN
        legal_f = legal_f || (funct == F_SLT);
`endif
        inv_new = (funct == F_SUB) || (funct == F_SLT);
        inv     = (op == F_SUB) || (op == F_SLT);
        bx      = b_sh[0] ^ inv;
        sum     = a_sh[0] ^ bx ^ c;
        c_nxt   = (a_sh[0] & bx) | ((a_sh[0] ^ bx) & c);
        case (op)
            F_AND:   bit_out = a_sh[0] & b_sh[0];
            F_OR:    bit_out = a_sh[0] | b_sh[0];
            default: bit_out = sum;
        endcase
        shifted = {bit_out, sh[WIDTH-1:1]};
`ifdef ALU_SERIAL_SLT_EN
        // The sign of the true difference is the MSB sum bit, corrected by overflow.
        less = s_msb ^ (c_msb_in ^ c_out);
`endif
    end

    // Sequencer: acceptance, serial bit walk, SLT fix-up and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            sh       <= '0;
            op       <= '0;
            c        <= 1'b0;
`ifdef ALU_SERIAL_SLT_EN
            c_msb_in <= 1'b0;
            c_out    <= 1'b0;
            s_msb    <= 1'b0;
`endif
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh <= a_in;
                        b_sh <= b_in;
                        op   <= funct;
                        cnt  <= '0;
                        sh   <= '0;
                        c    <= inv_new;
                        busy <= 1'b1;
                        if (legal_f) begin
                            err   <= 1'b0;
                            state <= S_RUN;
                        end else begin
                            err    <= 1'b1;
                            result <= '0;
                            zero   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= c_nxt;
                    sh   <= shifted;
                    if (cnt == LAST_BIT) begin
                        cnt <= '0;
`ifdef ALU_SERIAL_SLT_EN
                        c_msb_in <= c;
                        c_out    <= c_nxt;
                        s_msb    <= sum;
                        if (op == F_SLT) begin
                            state <= S_FIX;
                        end else begin
                            result <= shifted;
                            zero   <= (shifted == '0);
                            state  <= S_DONE;
                        end
`else
                        result <= shifted;
                        zero   <= (shifted == '0);
                        state  <= S_DONE;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef ALU_SERIAL_SLT_EN
                S_FIX: begin
                    result <= {{(WIDTH-1){1'b0}}, less};
                    zero   <= ~less;
                    state  <= S_DONE;
                end
`endif
                S_DONE: begin
                    // The first DONE cycle raises done; the second drops done and busy.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: scoreboard bench for alu_serial_ctrl (WIDTH=32).
// The driver pushes the expected {latency, err, zero, result} for each request
// it issues. A monitor forked from the same initial block pops one entry on
// every done and compares it.
module tb_alu_serial_ctrl;

    localparam int WIDTH = 32;
    localparam int W = WIDTH + 10;

    logic             clk;
    logic             rst;
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             err;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    int           cyc;
    int           errors;
    int           checks;
    logic         prev_done;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .result(result), .zero(zero), .err(err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef ALU_SERIAL_SLT_EN
    localparam bit SLT_EN = 1'b1;
`else
    localparam bit SLT_EN = 1'b0;
`endif

    // Reference model: {latency, err, zero, result}, computed with plain arithmetic.
    function automatic logic [W-1:0] model(input logic [5:0] f, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic [7:0]       lat;
        logic             e;
        e   = 1'b0;
        lat = 8'(WIDTH + 1);
        r   = '0;
        if (f == 6'd32) r = a + b;
        else if (f == 6'd34) r = a - b;
        else if (f == 6'd36) r = a & b;
        else if (f == 6'd37) r = a | b;
        else if (f == 6'd42 && SLT_EN) begin
            r   = ($signed(a) < $signed(b)) ? 1 : 0;
            lat = 8'(WIDTH + 2);
        end else begin
            e   = 1'b1;
            lat = 8'd1;
        end
        return {lat, e, (r == '0), r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy && !done) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: busy=%0b done=%0b still set after 200 cycles", busy, done);
    endtask

    // driver: issue one request; with hammer set, start is held high for the whole run.
    task automatic issue(input logic [5:0] f, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit hammer);
        wait_idle();
        start = 1'b1;
        funct = f;
        a_in  = a;
        b_in  = b;
        exp_q.push_back(model(f, a, b));
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        a_in  = $urandom;
        b_in  = $urandom;
        funct = 6'($urandom_range(0, 63));
        if (!hammer) start = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        if (hammer) begin
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (done) break;
            end
            start = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [5:0] fsel [7];
        logic [W-1:0] e;
        int lat;
        fsel = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd63, 6'd0};
        cyc = 0; errors = 0; checks = 0; prev_done = 1'b0;
        rst = 1'b1; start = 1'b0; funct = '0; a_in = '0; b_in = '0;

        // monitor: pop and compare on every done
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (prev_done) check("done_one_cycle", 64'(done), 64'd0);
                    if (done) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: done=1 with no pending request (cycle %0d)", cyc);
                        end else begin
                            e   = exp_q.pop_front();
                            lat = cyc - acc_q.pop_front();
                            check("result", 64'(result), 64'(e[WIDTH-1:0]));
                            check("zero", 64'(zero), 64'(e[WIDTH]));
                            check("err", 64'(err), 64'(e[WIDTH+1]));
                            check("latency", 64'(lat), 64'(e[WIDTH+9:WIDTH+2]));
                            check("busy_during_done", 64'(busy), 64'd1);
                        end
                    end
                    prev_done = done;
                end else begin
                    prev_done = 1'b0;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // directed vectors
        issue(6'd32, 32'd5, 32'd7, 1'b0);
        issue(6'd34, 32'd3, 32'd5, 1'b0);
        issue(6'd34, 32'h1234, 32'h1234, 1'b0);
        issue(6'd36, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
        issue(6'd37, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
        issue(6'd42, 32'hFFFFFFFF, 32'd1, 1'b0);
        issue(6'd42, 32'h80000000, 32'd1, 1'b0);
        issue(6'd42, 32'd1, 32'h80000000, 1'b0);
        issue(6'd63, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        issue(6'd42, 32'd3, 32'd9, 1'b0);
        issue(6'd32, 32'hFFFFFFFF, 32'd1, 1'b0);
        issue(6'd32, 32'd100, 32'd23, 1'b1);
        drain();

        // random mix including illegal codes
        for (int i = 0; i < 40; i++) begin
            issue(fsel[$urandom_range(0, 6)], $urandom, $urandom, ($urandom_range(0, 7) == 0));
        end
        drain();

        // reset during a run: previous result must clear and no done may follow
        issue(6'd32, 32'd40, 32'd2, 1'b0);
        drain();
        issue(6'd32, 32'd9, 32'd9, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_zero", 64'(zero), 64'd1);
        check("midrst_err", 64'(err), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(6'd32, 32'd1, 32'd1, 1'b0);
        drain();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
